// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle for the multi-read-port register file: read ports, writeback and issue-mark strobes.
// master = pipeline side that drives indices and strobes, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, post-reset clear sequencer and pending-write scoreboard.
// Reads are combinational; writes/marks land on the next edge; no backpressure. REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2
) (
  input logic        clock,
  input logic        reset,
  regfile_mp_if.slave rf
);
  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        clr_ptr;
  logic [NUM_REGS-1:0]      busy;
  logic [DATA_W-1:0]        mem [NUM_REGS];
  logic                     init_done_q;
  logic [(1<<ADDR_W)-1:0]   reg_ok;
  logic                     wr_ok;
  logic                     mark_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // reg_ok marks indices that hold real, writable state: not x0 and not beyond NUM_REGS
  for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_ok
    assign reg_ok[i] = (i != 0) && (i < NUM_REGS);
  end

  assign wr_ok   = (state == READY) && rf.wr_en   && reg_ok[rf.wr_addr];
  assign mark_ok = (state == READY) && rf.mark_en && reg_ok[rf.mark_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      busy        <= '0;
      init_done_q <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == ADDR_W'(NUM_REGS - 1)) begin
        state       <= READY;
        init_done_q <= 1'b1;
      end
    end else begin
      if (wr_ok) busy[rf.wr_addr] <= 1'b0;
      // Mark is applied last so a newer producer wins over a same-cycle release
      if (mark_ok) busy[rf.mark_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_ok)     mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rf.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (state == READY && reg_ok[addr]) begin
        data = mem[addr];
        bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (rf.wr_en && rf.wr_addr == addr) begin
          data = rf.wr_data;
          bsy  = rf.mark_en && (rf.mark_addr == addr);
        end
`endif
      end
    end

    assign rd_data_c[k*DATA_W +: DATA_W] = data;
    assign rd_busy_c[k]                  = bsy;
  end

  assign rf.rd_data   = rd_data_c;
  assign rf.rd_busy   = rd_busy_c;
  assign rf.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (4 read ports): clear sequence, x0, scoreboard, bypass timing, mid-clear reset.
module tb_regfile_mp;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 4;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) rf ();

  regfile_mp #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rf   (rf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rf.rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [63:0] rd(input int k);
    return rf.rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    rf.wr_en = 1'b1; rf.wr_addr = a; rf.wr_data = d;
    tick();
    rf.wr_en = 1'b0;
  endtask

  // Counts edges after reset release: init_done must rise on exactly edge NUM_REGS
  task automatic wait_init(input string tag);
    for (int e = 1; e <= NUM_REGS; e++) begin
      tick();
      check({tag, "_init_done"}, 64'(rf.init_done), 64'(e == NUM_REGS));
      if (e < NUM_REGS) begin
        check({tag, "_clear_data0"}, rd(0), 64'h0);
        check({tag, "_clear_busy"}, 64'(rf.rd_busy), 64'h0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    rf.rd_addr = '0; rf.wr_en = 1'b0; rf.wr_addr = '0; rf.wr_data = '0;
    rf.mark_en = 1'b0; rf.mark_addr = '0;
    set_rd(0, 5);
    tick(); tick();
    check("rst_init_done", 64'(rf.init_done), 64'h0);
    check("rst_data0", rd(0), 64'h0);
    check("rst_busy", 64'(rf.rd_busy), 64'h0);
    reset = 1'b0;
    wait_init("boot");

    // Clear sequence wipes reg 5 and drops writes issued during CLEAR
    write_reg(5, 64'hDEAD);
    check("pre_clear_r5", rd(0), 64'hDEAD);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rf.wr_en = 1'b1; rf.wr_addr = 5; rf.wr_data = 64'h5555;
    wait_init("clr");
    rf.wr_en = 1'b0;
    check("post_clear_r5", rd(0), 64'h0);

    // Basic write/read and x0
    write_reg(3, 64'h0123_4567_89AB_CDEF);
    write_reg(0, 64'hFFFF);
    set_rd(0, 3); set_rd(1, 0);
    #1;
    check("r3_read", rd(0), 64'h0123_4567_89AB_CDEF);
    check("x0_read", rd(1), 64'h0);
    check("x0_busy", 64'(rf.rd_busy[1]), 64'h0);

    // Scoreboard mark / release / mark-wins
    set_rd(0, 7);
    rf.mark_en = 1'b1; rf.mark_addr = 7;
    tick();
    rf.mark_en = 1'b0;
    check("mark_busy", 64'(rf.rd_busy[0]), 64'h1);
    write_reg(7, 64'h42);
    check("release_busy", 64'(rf.rd_busy[0]), 64'h0);
    check("release_data", rd(0), 64'h42);
    rf.mark_en = 1'b1; rf.mark_addr = 7;
    rf.wr_en = 1'b1; rf.wr_addr = 7; rf.wr_data = 64'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("mw_same_cyc_busy", 64'(rf.rd_busy[0]), 64'h1);
    check("mw_same_cyc_data", rd(0), 64'h99);
`else
    check("mw_same_cyc_busy", 64'(rf.rd_busy[0]), 64'h0);
    check("mw_same_cyc_data", rd(0), 64'h42);
`endif
    tick();
    rf.mark_en = 1'b0; rf.wr_en = 1'b0;
    check("mark_wins_busy", 64'(rf.rd_busy[0]), 64'h1);
    check("mark_wins_data", rd(0), 64'h99);

    // Bypass timing
    write_reg(9, 64'h11);
    set_rd(0, 9);
    rf.wr_en = 1'b1; rf.wr_addr = 9; rf.wr_data = 64'h22;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cyc", rd(0), 64'h22);
`else
    check("byp_same_cyc", rd(0), 64'h11);
`endif
    tick();
    rf.wr_en = 1'b0;
    check("byp_next_cyc", rd(0), 64'h22);

    // Multi-port: all four ports on a marked reg 12
    write_reg(12, 64'hABCD);
    rf.mark_en = 1'b1; rf.mark_addr = 12;
    tick();
    rf.mark_en = 1'b0;
    for (int k = 0; k < NUM_RD; k++) set_rd(k, 12);
    #1;
    for (int k = 0; k < NUM_RD; k++) check($sformatf("mp_data%0d", k), rd(k), 64'hABCD);
    check("mp_busy", 64'(rf.rd_busy), 64'hF);

    // Mark and write to different registers in one cycle
    rf.mark_en = 1'b1; rf.mark_addr = 13;
    rf.wr_en = 1'b1; rf.wr_addr = 14; rf.wr_data = 64'h77;
    tick();
    rf.mark_en = 1'b0; rf.wr_en = 1'b0;
    set_rd(0, 13); set_rd(1, 14);
    #1;
    check("diff_mark_busy", 64'(rf.rd_busy[0]), 64'h1);
    check("diff_wr_data", rd(1), 64'h77);
    check("diff_wr_busy", 64'(rf.rd_busy[1]), 64'h0);

    // Reset mid-clear restarts the sequence; marks during CLEAR are dropped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("midclr_init_done", 64'(rf.init_done), 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_rd(0, 20); set_rd(1, 12);
    rf.mark_en = 1'b1; rf.mark_addr = 20;
    wait_init("midclr");
    rf.mark_en = 1'b0;
    #1;
    check("clr_mark_dropped", 64'(rf.rd_busy[0]), 64'h0);
    check("r12_recleared", rd(1), 64'h0);
    check("r12_busy_cleared", 64'(rf.rd_busy[1]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the pipelined core, the next generation of the single-issue 2R1W file.
- Adds:
  - an architectural-zero register
  - a hardware clear sequencer after reset
  - a per-register pending-write scoreboard for hazard detection
  - optional write-to-read bypass
- Sits between decode (read and mark) and writeback (write and release).

Parameters:
- DATA_W, 64, width of each register in bits
- NUM_REGS, 32, number of architectural registers (power of two, 2..64)
- ADDR_W, 5, register index width; must equal log2(NUM_REGS)
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard bit of the register addressed by port k
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- mark_en  in  1  issue strobe: destination now has an in-flight producer
- mark_addr  in  ADDR_W  destination being marked
- init_done  out  1  high once the clear sequence has completed

Behaviour:
- Storage: NUM_REGS x DATA_W array plus a NUM_REGS-bit busy vector. Register 0 always reads 0, is never busy, and ignores writes and marks.
- State machine (2 states, CLEAR and READY):
  - When reset is high: state <= CLEAR, clr_ptr <= 0, busy <= all 0, init_done <= 0.
  - In CLEAR with reset low, each cycle: mem[clr_ptr] <= 0, clr_ptr <= clr_ptr+1. When clr_ptr == NUM_REGS-1: state <= READY, init_done <= 1.
  - init_done therefore rises exactly NUM_REGS rising edges after reset deasserts.
  - READY persists until the next reset.
- In CLEAR:
  - All rd_data = 0 and all rd_busy = 0.
  - wr_en and mark_en are ignored and dropped; no queueing.
- Reset mid-CLEAR: the sequence restarts at clr_ptr = 0. Reset in READY: re-enters CLEAR; memory contents are re-cleared by the sequence.
- Reads (READY): combinational, zero latency.
  - rd_data[k] = mem[rd_addr[k]], or 0 if rd_addr[k] == 0.
  - rd_busy[k] = busy[rd_addr[k]].
- Write (READY): if wr_en and wr_addr != 0, then on the rising edge mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Mark (READY): if mark_en and mark_addr != 0, then on the rising edge busy[mark_addr] <= 1.
- Simultaneous mark and write to the same address: mark wins and busy ends at 1, because a newer producer was issued. The data write still occurs.
- Simultaneous mark and write to different addresses: both take effect.
- Any number of read ports may address the same register.
- Out-of-range addresses (>= NUM_REGS, only possible with non-power-of-two misuse) read 0, are never busy, and writes to them are ignored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in READY, if wr_en and wr_addr == rd_addr[k] and wr_addr != 0, then:
  - rd_data[k] = wr_data in the same cycle (write-to-read forwarding);
  - rd_busy[k] = 0, unless a mark_en to the same address is also active that cycle, in which case rd_busy[k] = 1.
- Not defined: reads return the pre-write array value and busy bit; the new value and busy clear are visible from the next cycle.

Test Plan:
1. Clear sequence: write reg 5 = 0xDEAD, then reset high for 2 cycles then low -> init_done = 0 for edges 1..31 and 1 at edge 32 (NUM_REGS=32). During CLEAR, rd_data = 0 and writes are dropped. After init_done, reg 5 reads 0.
2. Basic write/read plus x0: write reg 3 = 0x0123_4567_89AB_CDEF and reg 0 = 0xFFFF -> next cycle port0 @3 reads 0x0123_4567_89AB_CDEF and port1 @0 reads 0.
3. Scoreboard: mark reg 7 -> rd_busy = 1 on the following cycle. Write reg 7 = 0x42 -> busy = 0 next cycle. Mark and write reg 7 in the same cycle -> busy = 1 and data = the written value.
4. Bypass: reg 9 = 0x11, then in one cycle write reg 9 = 0x22 while port0 reads 9 -> with REGFILE_BYPASS_EN, rd_data0 = 0x22 that cycle. Without it, rd_data0 = 0x11, and 0x22 the next cycle.
5. Reset mid-clear: reassert reset 10 cycles into CLEAR, release -> init_done rises 32 edges after the second release. A mark issued during CLEAR leaves busy = 0.
6. Multi-port: NUM_RD=4, all four ports address reg 12 = 0xABCD, with reg 12 marked -> all rd_data = 0xABCD and all rd_busy = 1.
